// File: rtl/alu_dp_sequencer.sv
// Issues one ARM data-processing instruction at a time to the shared ALU,
// holds its inputs for EXEC_CYCLES, then updates NZCV and writes back.
module alu_dp_sequencer #(
    parameter int EXEC_CYCLES = 2,
    parameter int WIDTH       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_opcode,
    input  logic             req_s,
    input  logic [3:0]       req_rd,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    input  logic             req_shift_c,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    output logic             wb_valid,
    output logic [3:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [3:0]       nzcv,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [4:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic [3:0]       rd_q, rd_d;
    logic             setf_q, setf_d;
    logic             arith_q, arith_d;
    logic             wbop_q, wbop_d;
    logic             shc_q, shc_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [3:0]       wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;

    logic [4:0] map_op;
    logic       map_arith;
    logic       is_cmp;

    always_comb begin
        map_op    = 5'b00000;
        map_arith = 1'b0;
        case (req_opcode)
            4'b0000: map_op = 5'b00000;
            4'b0001: map_op = 5'b00011;
            4'b0010: begin map_op = 5'b00110; map_arith = 1'b1; end
            4'b0011: begin map_op = 5'b01000; map_arith = 1'b1; end
            4'b0100: begin map_op = 5'b00100; map_arith = 1'b1; end
            4'b0101: begin map_op = 5'b00101; map_arith = 1'b1; end
            4'b0110: begin map_op = 5'b00111; map_arith = 1'b1; end
            4'b0111: begin map_op = 5'b01001; map_arith = 1'b1; end
            4'b1000: map_op = 5'b00000;
            4'b1001: map_op = 5'b00011;
            4'b1010: begin map_op = 5'b00110; map_arith = 1'b1; end
            4'b1011: begin map_op = 5'b00100; map_arith = 1'b1; end
            4'b1100: map_op = 5'b00010;
            4'b1101: map_op = 5'b01010;
            4'b1110: map_op = 5'b00001;
            default: map_op = 5'b01011;
        endcase
    end

    // TST/TEQ/CMP/CMN occupy opcodes 10xx
    assign is_cmp = (req_opcode[3:2] == 2'b10);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cin_d     = cin_q;
        rd_d      = rd_q;
        setf_d    = setf_q;
        arith_d   = arith_q;
        wbop_d    = wbop_q;
        shc_d     = shc_q;
        nzcv_d    = nzcv_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        req_ready = (state_q == IDLE) && !flush;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    a_d     = req_op1;
                    b_d     = req_op2;
                    op_d    = map_op;
                    cin_d   = nzcv_q[1];
                    rd_d    = req_rd;
                    setf_d  = req_s || is_cmp;
                    arith_d = map_arith;
                    wbop_d  = !is_cmp;
                    shc_d   = req_shift_c;
                    cnt_d   = CNT_INIT;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // flush beats completion, even on the last cycle
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    if (setf_q)
                        nzcv_d = arith_q ? {alu_n, alu_z, alu_c, alu_v}
                                         : {alu_n, alu_z, shc_q, nzcv_q[0]};
                    if (wbop_q) begin
                        wb_data_d = alu_out;
                        wb_rd_d   = rd_q;
                        state_d   = WB;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            cin_q     <= 1'b0;
            rd_q      <= '0;
            setf_q    <= 1'b0;
            arith_q   <= 1'b0;
            wbop_q    <= 1'b0;
            shc_q     <= 1'b0;
            nzcv_q    <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            cin_q     <= cin_d;
            rd_q      <= rd_d;
            setf_q    <= setf_d;
            arith_q   <= arith_d;
            wbop_q    <= wbop_d;
            shc_q     <= shc_d;
            nzcv_q    <= nzcv_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign alu_cin  = cin_q;
    assign wb_valid = (state_q == WB);
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign nzcv     = nzcv_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_dp_sequencer.sv
// Randomized scoreboard bench for alu_dp_sequencer with a stand-in ALU and
// an ARM-semantics reference model.
module tb_alu_dp_sequencer;

    localparam int E = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_s, req_shift_c, flush;
    logic [3:0]  req_opcode, req_rd;
    logic [31:0] req_op1, req_op2;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_op;
    logic        alu_cin, alu_c, alu_z, alu_n, alu_v;
    logic        wb_valid, busy;
    logic [3:0]  wb_rd, nzcv;
    logic [31:0] wb_data;

    alu_dp_sequencer #(.EXEC_CYCLES(E), .WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_s(req_s), .req_rd(req_rd), .req_op1(req_op1), .req_op2(req_op2),
        .req_shift_c(req_shift_c), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .nzcv(nzcv), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in combinational ALU
    logic [31:0] ax, ay, lr;
    logic        aci, aar;
    logic [32:0] asum;
    always_comb begin
        ax = alu_a; ay = alu_b; aci = 1'b0; aar = 1'b1; lr = '0;
        case (alu_op)
            5'd4: ;
            5'd5: aci = alu_cin;
            5'd6: begin ay = ~alu_b; aci = 1'b1; end
            5'd7: begin ay = ~alu_b; aci = alu_cin; end
            5'd8: begin ax = alu_b; ay = ~alu_a; aci = 1'b1; end
            5'd9: begin ax = alu_b; ay = ~alu_a; aci = alu_cin; end
            default: aar = 1'b0;
        endcase
        asum = {1'b0, ax} + {1'b0, ay} + {32'b0, aci};
        case (alu_op)
            5'd0:    lr = alu_a & alu_b;
            5'd1:    lr = alu_a & ~alu_b;
            5'd2:    lr = alu_a | alu_b;
            5'd3:    lr = alu_a ^ alu_b;
            5'd10:   lr = alu_b;
            5'd11:   lr = ~alu_b;
            default: lr = '0;
        endcase
        alu_out = aar ? asum[31:0] : lr;
        alu_c   = aar & asum[32];
        alu_v   = aar & (ax[31] == ay[31]) & (asum[31] != ax[31]);
        alu_n   = alu_out[31];
        alu_z   = (alu_out == 32'd0);
    end

    localparam logic [4:0] OPMAP [16] = '{5'b00000, 5'b00011, 5'b00110, 5'b01000,
                                          5'b00100, 5'b00101, 5'b00111, 5'b01001,
                                          5'b00000, 5'b00011, 5'b00110, 5'b00100,
                                          5'b00010, 5'b01010, 5'b00001, 5'b01011};

    typedef struct { logic [3:0] rd; logic [31:0] data; int cyc; } wb_exp_t;
    wb_exp_t    wbq[$];
    logic [3:0] nzq[$];
    logic [3:0] mdl_nzcv = 4'b0000;
    int         total = 0, passed = 0;
    bit         mon_en = 1'b0;
    bit         prev_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ARM data-processing semantics computed with wide integer arithmetic
    function automatic void ref_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                                   input logic shc, input logic [3:0] f,
                                   output logic [31:0] r, output logic [3:0] nf);
        longint ua, ub, sa, sb, ci, uu, ss;
        bit arith, add, c, v;
        ua = {32'b0, a}; ub = {32'b0, b};
        sa = $signed(a); sb = $signed(b);
        ci = {63'b0, f[1]};
        arith = 1'b1; add = 1'b1; uu = 0; ss = 0; r = '0;
        case (opc)
            4'h0, 4'h8: begin arith = 0; r = a & b; end
            4'h1, 4'h9: begin arith = 0; r = a ^ b; end
            4'hC:       begin arith = 0; r = a | b; end
            4'hD:       begin arith = 0; r = b; end
            4'hE:       begin arith = 0; r = a & ~b; end
            4'hF:       begin arith = 0; r = ~b; end
            4'h4, 4'hB: begin uu = ua + ub; ss = sa + sb; end
            4'h5:       begin uu = ua + ub + ci; ss = sa + sb + ci; end
            4'h2, 4'hA: begin add = 0; uu = ua - ub; ss = sa - sb; end
            4'h6:       begin add = 0; uu = ua - ub - (1 - ci); ss = sa - sb - (1 - ci); end
            4'h3:       begin add = 0; uu = ub - ua; ss = sb - sa; end
            default:    begin add = 0; uu = ub - ua - (1 - ci); ss = sb - sa - (1 - ci); end
        endcase
        if (arith) begin
            r  = uu[31:0];
            c  = add ? (uu > 64'sd4294967295) : (uu >= 0);
            v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            nf = {r[31], r == 32'd0, c, v};
        end else begin
            nf = {r[31], r == 32'd0, shc, f[0]};
        end
    endfunction

    // fl_at: -1 none, 0..E-1 flush in that EXEC cycle, E flush during WB
    task automatic do_op(input logic [3:0] opc, input logic s, input logic [3:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic shc, input int fl_at);
        int t, e_done, n;
        bit wbop, flushed;
        logic [31:0] r;
        logic [3:0]  nf;
        @(negedge clk);
        req_opcode = opc; req_s = s; req_rd = rd; req_op1 = a; req_op2 = b;
        req_shift_c = shc; req_valid = 1'b1;
        check("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        t = cyc;
        req_valid = 1'b0;
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_op", alu_op, OPMAP[opc]);
        check("alu_cin", alu_cin, mdl_nzcv[1]);
        req_opcode = 4'($urandom); req_s = 1'($urandom); req_rd = 4'($urandom);
        req_op1 = $urandom; req_op2 = $urandom; req_shift_c = 1'($urandom);

        wbop    = (opc[3:2] != 2'b10);
        flushed = (fl_at >= 0) && (fl_at < E);
        ref_op(opc, a, b, shc, mdl_nzcv, r, nf);
        if (!flushed) begin
            if (s || !wbop) mdl_nzcv = nf;
            if (wbop) wbq.push_back('{rd: rd, data: r, cyc: t + E});
        end
        nzq.push_back(mdl_nzcv);
        e_done = flushed ? t + fl_at + 1 : (wbop ? t + E + 1 : t + E);

        if (fl_at >= 0) begin
            if (fl_at > 0) begin repeat (fl_at) @(posedge clk); #1; end
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("done_timeout", 1, 0);
        else check("done_cycle", cyc, e_done);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 3))
            0: return 32'h7FFFFFFF + $urandom_range(0, 2);
            1: return 32'hFFFFFFFF - $urandom_range(0, 2);
            2: return $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        wb_exp_t e;
        if (mon_en && reset_n) begin
            if (wb_valid) begin
                if (wbq.size() == 0) check("wb_unexpected", 1, 0);
                else begin
                    e = wbq.pop_front();
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_data", wb_data, e.data);
                    check("wb_cycle", cyc, e.cyc);
                end
            end
            if (prev_busy && !busy) begin
                if (nzq.size() == 0) check("nzcv_unexpected", 1, 0);
                else check("nzcv", nzcv, nzq.pop_front());
            end
            prev_busy = busy;
        end else begin
            prev_busy = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; flush = 1'b0; req_opcode = '0; req_s = 1'b0;
        req_rd = '0; req_op1 = '0; req_op2 = '0; req_shift_c = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_nzcv", nzcv, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); reset_n = 1'b1; #1;
        check("rst_req_ready", req_ready, 1);
        mon_en = 1'b1;

        do_op(4'h4, 1, 4'd3, 32'h7FFFFFFF, 32'd1, 0, -1);
        check("add_nzcv", nzcv, 4'b1001);
        check("add_wb_data", wb_data, 32'h80000000);
        do_op(4'h0, 1, 4'd4, 32'hA, 32'h2, 1, -1);
        check("ands_nzcv", nzcv, 4'b0011);
        check("ands_wb_data", wb_data, 32'h2);
        do_op(4'hA, 0, 4'd5, 32'd5, 32'd5, 0, -1);
        check("cmp_nzcv", nzcv, 4'b0110);
        do_op(4'h4, 1, 4'd6, 32'hFFFFFFFF, 32'd1, 0, -1);
        check("addc_nzcv", nzcv, 4'b0110);
        do_op(4'h5, 0, 4'd7, 32'd1, 32'd2, 0, -1);
        check("adc_wb_data", wb_data, 32'd4);
        check("adc_nzcv", nzcv, 4'b0110);
        do_op(4'h2, 1, 4'd8, 32'd9, 32'd3, 0, E - 1);
        check("flush_nzcv", nzcv, 4'b0110);
        check("flush_wb_data", wb_data, 32'd4);

        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_opcode = 4'h4; #1;
        check("flush_idle_ready", req_ready, 0);
        @(posedge clk); #1;
        check("flush_idle_busy", busy, 0);
        flush = 1'b0; req_valid = 1'b0;

        for (int i = 0; i < 150; i++) begin
            logic [3:0] opc;
            int fl;
            opc = 4'($urandom);
            fl = -1;
            if ($urandom_range(0, 5) == 0) fl = $urandom_range(0, (opc[3:2] != 2'b10) ? E : E - 1);
            do_op(opc, 1'($urandom), 4'($urandom), rnd32(), rnd32(), 1'($urandom), fl);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        mon_en = 1'b0;
        @(negedge clk);
        req_opcode = 4'h4; req_s = 1'b1; req_op1 = 32'h5; req_op2 = 32'h7; req_rd = 4'd9;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0; #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_alu_op", alu_op, 0);
        check("mid_rst_alu_cin", alu_cin, 0);
        check("mid_rst_nzcv", nzcv, 0);
        check("mid_rst_wb", {wb_valid, wb_rd, wb_data}, 0);
        wbq.delete(); nzq.delete(); mdl_nzcv = 4'b0000;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); mon_en = 1'b1;

        for (int i = 0; i < 20; i++)
            do_op(4'($urandom), 1'($urandom), 4'($urandom), rnd32(), rnd32(), 1'($urandom), -1);

        repeat (3) @(negedge clk);
        check("wbq_empty", wbq.size(), 0);
        check("nzq_empty", nzq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
